// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package mem_arb_pkg;

  // Owner of the memory during the last cycle
  typedef enum logic [1:0] {
    IDLE,
    CORE,
    DMA,
    DMA_LOCK
  } arb_state_e;

  // Owner encoding for the current-cycle winner
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CORE = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data RAM.
// slave: arbiter side; master: requesters + memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              dma_req;
  logic              dma_we;
  logic              dma_lock;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing the single-port data RAM between the core
// data port and a DMA/accelerator port. Core has priority except during a
// locked DMA burst (capped at MAX_BURST beats) or a starvation-forced grant.
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN (starvation guard).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_BURST  = 4,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int BW = $clog2(MAX_BURST + 1);

  if (MAX_BURST < 1 || STARVE_LIM < 1) begin : g_cfg_err
    $error("mem_arbiter: MAX_BURST and STARVE_LIM must be >= 1");
  end

  arb_state_e    state, state_nxt;
  logic [BW-1:0] beat_cnt, beat_nxt;
  logic [1:0]    owner;
  logic          core_gnt, dma_gnt;
  logic          starve_hit;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIM + 1);
  logic [SW-1:0] starve_cnt;

  // Count consecutive denied DMA cycles, saturating at the limit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      starve_cnt <= '0;
    else if (dma_gnt || !bus.dma_req)
      starve_cnt <= '0;
    else if (starve_cnt != SW'(STARVE_LIM))
      starve_cnt <= starve_cnt + SW'(1);
  end

  assign starve_hit = (starve_cnt == SW'(STARVE_LIM));
`else
  assign starve_hit = 1'b0;
`endif

  // Priority resolver; reset forces no winner
  always_comb begin
    owner = OWN_NONE;
    if (bus.dma_req && (state == DMA_LOCK || starve_hit))
      owner = OWN_DMA;
    else if (bus.core_req)
      owner = OWN_CORE;
    else if (bus.dma_req)
      owner = OWN_DMA;
    if (!reset)
      owner = OWN_NONE;
  end

  assign core_gnt     = (owner == OWN_CORE);
  assign dma_gnt      = (owner == OWN_DMA);
  assign bus.core_gnt = core_gnt;
  assign bus.dma_gnt  = dma_gnt;
  assign bus.mem_en   = core_gnt | dma_gnt;

  // Memory-side mux driven by the winner, zero when idle
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (owner)
      OWN_CORE: begin
        bus.mem_we    = bus.core_we;
        bus.mem_addr  = bus.core_addr;
        bus.mem_wdata = bus.core_wdata;
      end
      OWN_DMA: begin
        bus.mem_we    = bus.dma_we;
        bus.mem_addr  = bus.dma_addr;
        bus.mem_wdata = bus.dma_wdata;
      end
      default: ;
    endcase
  end

  // Next owner state and locked-burst beat count
  always_comb begin
    state_nxt = IDLE;
    beat_nxt  = '0;
    if (dma_gnt && bus.dma_lock &&
        ((32'(beat_cnt) + 32'd1) < 32'(MAX_BURST))) begin
      state_nxt = DMA_LOCK;
      beat_nxt  = beat_cnt + BW'(1);
    end else if (dma_gnt) begin
      state_nxt = DMA;
    end else if (core_gnt) begin
      state_nxt = CORE;
    end
  end

  // State and beat-count registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  // Read-return valids, one cycle after a read grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.core_rvalid <= 1'b0;
      bus.dma_rvalid  <= 1'b0;
    end else begin
      bus.core_rvalid <= core_gnt & ~bus.core_we;
      bus.dma_rvalid  <= dma_gnt & ~bus.dma_we;
    end
  end

  assign bus.core_rdata = bus.mem_rdata;
  assign bus.dma_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus hand-written sequences
// for reset, contention, locked bursts and reset during a pending read.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_BURST(4), .STARVE_LIM(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_lock = 1'b0;
    bus.dma_addr = '0; bus.dma_wdata = '0; bus.mem_rdata = '0;
  endtask

  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        dr, dw;
    logic [31:0] da, dd;
    logic [31:0] mrd;
    logic [3:0]  e_gnt;   // {core_gnt, dma_gnt, mem_en, mem_we}
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_rv;    // {core_rvalid, dma_rvalid}
  } vec_t;

  vec_t vt[10];

  logic breq[8]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic bisdma[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int   beats;
    logic exp_dma;

    vt[0] = '{1'b0,1'b0,32'h0,32'h0,       1'b0,1'b0,32'h0,32'h0,        32'h0,        4'b0000,32'h0, 32'h0,    2'b00};
    vt[1] = '{1'b1,1'b0,32'h10,32'h55,     1'b0,1'b0,32'h0,32'h0,        32'h0,        4'b1010,32'h10,32'h55,   2'b00};
    vt[2] = '{1'b0,1'b0,32'h0,32'h0,       1'b0,1'b0,32'h0,32'h0,        32'hAABBCCDD, 4'b0000,32'h0, 32'h0,    2'b10};
    vt[3] = '{1'b0,1'b0,32'h0,32'h0,       1'b1,1'b1,32'h20,32'h1234,    32'h0,        4'b0111,32'h20,32'h1234, 2'b00};
    vt[4] = '{1'b1,1'b1,32'h30,32'hCAFE,   1'b1,1'b0,32'h40,32'h99,      32'h0,        4'b1011,32'h30,32'hCAFE, 2'b00};
    vt[5] = '{1'b0,1'b0,32'h0,32'h0,       1'b1,1'b0,32'h40,32'h99,      32'h0,        4'b0110,32'h40,32'h99,   2'b00};
    vt[6] = '{1'b1,1'b0,32'h50,32'h0,      1'b0,1'b0,32'h0,32'h0,        32'h11112222, 4'b1010,32'h50,32'h0,    2'b01};
    vt[7] = '{1'b0,1'b0,32'h0,32'h0,       1'b1,1'b0,32'h60,32'h7,       32'h33334444, 4'b0110,32'h60,32'h7,    2'b10};
    vt[8] = '{1'b0,1'b0,32'h0,32'h0,       1'b0,1'b0,32'h0,32'h0,        32'h55556666, 4'b0000,32'h0, 32'h0,    2'b01};
    vt[9] = '{1'b0,1'b0,32'h0,32'h0,       1'b0,1'b0,32'h0,32'h0,        32'h0,        4'b0000,32'h0, 32'h0,    2'b00};

    // Reset held with both requesters active
    drive_idle();
    reset = 1'b0;
    bus.core_req = 1'b1; bus.core_addr = 32'h10;
    bus.dma_req = 1'b1; bus.dma_addr = 32'h20; bus.dma_we = 1'b1; bus.dma_wdata = 32'h77;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 64'({bus.core_gnt, bus.dma_gnt, bus.mem_en, bus.mem_we}), 64'(4'b0000));
    check("rst_rvalid", 64'({bus.core_rvalid, bus.dma_rvalid}), 64'(2'b00));
    check("rst_addr", 64'(bus.mem_addr), 64'(32'h0));
    check("rst_wdata", 64'(bus.mem_wdata), 64'(32'h0));
    drive_idle();
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("idle_en", 64'(bus.mem_en), 64'(1'b0));
    @(negedge clk);
    check("idle_state", 64'(dut.state), 64'(IDLE));

    // Table-driven single-cycle vectors
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.core_req = vt[i].cr; bus.core_we = vt[i].cw;
      bus.core_addr = vt[i].ca; bus.core_wdata = vt[i].cd;
      bus.dma_req = vt[i].dr; bus.dma_we = vt[i].dw; bus.dma_lock = 1'b0;
      bus.dma_addr = vt[i].da; bus.dma_wdata = vt[i].dd;
      bus.mem_rdata = vt[i].mrd;
      @(negedge clk);
      check($sformatf("v%0d_gnt", i),
            64'({bus.core_gnt, bus.dma_gnt, bus.mem_en, bus.mem_we}), 64'(vt[i].e_gnt));
      check($sformatf("v%0d_addr", i), 64'(bus.mem_addr), 64'(vt[i].e_addr));
      check($sformatf("v%0d_wdata", i), 64'(bus.mem_wdata), 64'(vt[i].e_wdata));
      check($sformatf("v%0d_rvalid", i),
            64'({bus.core_rvalid, bus.dma_rvalid}), 64'(vt[i].e_rv));
      if (vt[i].e_rv[1]) check($sformatf("v%0d_core_rdata", i), 64'(bus.core_rdata), 64'(vt[i].mrd));
      if (vt[i].e_rv[0]) check($sformatf("v%0d_dma_rdata", i), 64'(bus.dma_rdata), 64'(vt[i].mrd));
    end

    // Continuous contention for 20 cycles, no lock
    @(posedge clk); #1;
    drive_idle();
    bus.core_req = 1'b1; bus.core_addr = 32'h300;
    bus.dma_req = 1'b1; bus.dma_addr = 32'h400;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_dma = ((i % 5) == 4);
`else
      exp_dma = 1'b0;
`endif
      check($sformatf("contend%0d", i), 64'({bus.core_gnt, bus.dma_gnt}), 64'({~exp_dma, exp_dma}));
      @(posedge clk);
    end
    #1;
    drive_idle();

    // Locked DMA write burst of 6 beats, core joins in cycle 1
    @(posedge clk);
    beats = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_lock = 1'b1;
      bus.dma_addr = 32'h100 + 32'(beats); bus.dma_wdata = 32'hD000 + 32'(beats);
      bus.core_req = breq[c]; bus.core_we = 1'b0; bus.core_addr = 32'h200;
      @(negedge clk);
      check($sformatf("burst%0d_gnt", c), 64'({bus.core_gnt, bus.dma_gnt}),
            64'({~bisdma[c], bisdma[c]}));
      check($sformatf("burst%0d_addr", c), 64'(bus.mem_addr),
            bisdma[c] ? 64'(32'h100 + 32'(beats)) : 64'(32'h200));
      check($sformatf("burst%0d_rvalid", c), 64'({bus.core_rvalid, bus.dma_rvalid}),
            64'({(c > 0) && !bisdma[(c > 0) ? c - 1 : 0], 1'b0}));
      if (bisdma[c]) beats++;
    end
    @(posedge clk); #1;
    drive_idle();

    // Reset asserted between a core read grant and its return
    @(posedge clk); #1;
    bus.core_req = 1'b1; bus.core_addr = 32'h10;
    @(negedge clk);
    check("midrd_gnt", 64'(bus.core_gnt), 64'(1'b1));
    #2;
    reset = 1'b0;
    #1;
    check("midrd_gnt_forced", 64'({bus.core_gnt, bus.mem_en}), 64'(2'b00));
    @(posedge clk); #1;
    check("midrd_rvalid_in_rst", 64'(bus.core_rvalid), 64'(1'b0));
    bus.core_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrd_rvalid_after", 64'(bus.core_rvalid), 64'(1'b0));
    check("midrd_state", 64'(dut.state), 64'(IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port data memory between the ARM core's data port and a DMA/accelerator port. It sits between the core's data-side signals (MemWrite, ALUResult as address, WriteData, ReadData) and the data RAM. It resolves priority each cycle, supports locked DMA bursts, routes read data back one cycle later, and can optionally prevent DMA starvation.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_BURST, 4, maximum consecutive locked DMA beats while the core is waiting; must be ≥ 1
- STARVE_LIM, 4, consecutive denied DMA cycles before a forced DMA grant; used only with the macro
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- core_req / core_we  in  1 / 1  core access request / write enable
- core_addr / core_wdata  in  ADDR_W / DATA_W  core address / write data
- core_gnt  out  1  core granted this cycle (combinational)
- core_rvalid / core_rdata  out  1 / DATA_W  core read return
- dma_req / dma_we / dma_lock  in  1 / 1 / 1  DMA request / write enable / burst lock
- dma_addr / dma_wdata  in  ADDR_W / DATA_W  DMA address / write data
- dma_gnt  out  1  DMA granted this cycle (combinational)
- dma_rvalid / dma_rdata  out  1 / DATA_W  DMA read return
- mem_en / mem_we  out  1 / 1  memory enable / write enable
- mem_addr / mem_wdata  out  ADDR_W / DATA_W  muxed address / write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read enable

## Operation
- **Priority, evaluated each cycle.** DMA wins if dma_req and (state==DMA_LOCK or starve_hit). Otherwise core wins if core_req. Otherwise DMA wins if dma_req. Otherwise no grant.
- **Grants.** At most one grant per cycle. mem_en = core_gnt | dma_gnt. mem_we, mem_addr and mem_wdata come from the winner; all are 0 when there is no grant.
- **Grant handshake.** A grant completes one transfer. A requester holds req/we/addr/wdata stable until it samples gnt=1 at a rising edge.
- **States:** IDLE, CORE, DMA, DMA_LOCK. State records the owner of the last cycle. beat_cnt has width $clog2(MAX_BURST+1).
- **Next-state rules:**
  - dma_gnt & dma_lock & (beat_cnt+1 < MAX_BURST) → DMA_LOCK, beat_cnt+1.
  - Else dma_gnt → DMA, beat_cnt 0.
  - Else core_gnt → CORE, beat_cnt 0.
  - Else → IDLE, beat_cnt 0.
- **Burst limit.** A locked burst ends on the MAX_BURST-th beat, when dma_lock drops, or when dma_req drops. After that, the core has priority again for at least one cycle.
- **Read return.** core_rvalid is registered as core_gnt & ~core_we; dma_rvalid likewise. Both rdata outputs equal mem_rdata. Only the owning requester's rvalid is 1. Writes produce no rvalid.

## Timing
- **Combinational paths.** req→gnt and req→mem_* are combinational, with zero latency. The read-data latency is exactly 1 cycle after the grant.
- **Throughput.** Back-to-back grants are allowed every cycle, including an owner change on consecutive cycles. Read returns for different owners never collide.
- **Reset values (reset=0).** State IDLE, beat_cnt 0, starve_cnt 0, core_rvalid 0, dma_rvalid 0. core_gnt, dma_gnt, mem_en and mem_we are forced to 0; mem_addr and mem_wdata are 0.
- **Reset mid-operation.** Reset takes effect asynchronously. A pending read return is discarded (rvalid stays 0). A locked burst is aborted.
- **Simultaneous requests.** With no lock and no starvation, the core wins.

## Configuration
- MEM_ARB_STARVE_GUARD_EN **defined:**
  - starve_cnt, width $clog2(STARVE_LIM+1), increments each cycle dma_req & ~dma_gnt and saturates at STARVE_LIM.
  - starve_cnt clears on dma_gnt or ~dma_req.
  - starve_hit = (starve_cnt == STARVE_LIM). When it fires, DMA receives one grant over the core.
- MEM_ARB_STARVE_GUARD_EN **undefined:** no counter exists and starve_hit is constant 0, giving pure core priority apart from locked bursts.

## Structure
- **Package mem_arb_pkg:** the state enum (IDLE, CORE, DMA, DMA_LOCK) and owner encoding constants.
- **Module layout:** a single module; no sub-module is needed. The priority resolver, FSM, counters and read-return registers are all local.

## Test plan
- **Reset and idle.** Hold reset=0 with both requests high → both gnt, both rvalid and mem_en are 0. Release reset with no requests → mem_en stays 0 and state is IDLE.
- **Core read.** Core reads 0x10 and memory returns 0xAABBCCDD → core_gnt=1 and mem_addr=0x10 in the same cycle. The next cycle core_rvalid=1 with core_rdata=0xAABBCCDD, and dma_rvalid=0.
- **Simultaneous requests, macro off.** Both request continuously for 20 cycles with dma_lock=0 → core_gnt=1 every cycle and dma_gnt never asserts.
- **Starvation guard, macro on, STARVE_LIM=4.** Both request continuously → core granted cycles 0–3, DMA cycle 4, core 5–8, DMA 9, repeating.
- **Locked burst, MAX_BURST=4.** Core idle; DMA locked write burst of 6 beats starting at 0x100; core_req rises in cycle 1 → dma_gnt in cycles 0–3 (0x100–0x103), core_gnt from cycle 4, and DMA resumes only once the core is not requesting.
- **Reset mid-read.** Core read granted; reset asserted before the following edge → core_rvalid stays 0 and state is IDLE after reset is released.
